// File: rtl/baby_store_controller.sv
// Sequencer between the Baby store logic and a bank of parallel 2114 SRAMs.
// Turns a one-cycle request into timed read or write cycles and owns the data bus.
module baby_store_controller #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 3,
  parameter int HOLD_CYCLES  = 1,
  parameter int READ_CYCLES  = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [DATA_WIDTH-1:0] sram_dq,
  output logic                  sram_cs_n,
  output logic                  sram_we_n
);

  // state    | meaning
  // IDLE     | waiting for req; bus released, chips deselected
  // W_SETUP  | address and data settle with chips deselected
  // W_PULSE  | CS_n and WE_n both low, write in progress
  // W_HOLD   | strobe released, address and data still held
  // R_ACCESS | CS_n low, chips drive the bus; captured on the last edge
  // DONE     | one-cycle completion pulse

  localparam int MAX_A   = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int MAX_B   = (HOLD_CYCLES > READ_CYCLES) ? HOLD_CYCLES : READ_CYCLES;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] READ_LD  = CNT_W'(READ_CYCLES - 1);

  if (SETUP_CYCLES < 1 || PULSE_CYCLES < 1 || HOLD_CYCLES < 1 || READ_CYCLES < 1) begin : g_bad_cycles
    $error("baby_store_controller: every cycle parameter must be at least 1");
  end
  if (DATA_WIDTH % 4 != 0) begin : g_bad_width
    $error("baby_store_controller: DATA_WIDTH must be a multiple of 4");
  end

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_PULSE,
    W_HOLD,
    R_ACCESS,
    DONE
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  dq_oe;

  // Bus is only driven across setup/pulse/hold, never while the chips are reading.
  assign sram_dq = dq_oe ? wdata_q : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      wdata_q   <= '0;
      dq_oe     <= 1'b0;
      sram_addr <= '0;
      sram_cs_n <= 1'b1;
      sram_we_n <= 1'b1;
      rdata     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            sram_addr <= addr;
            wdata_q   <= wdata;
            busy      <= 1'b1;
            if (write) begin
              state <= W_SETUP;
              cnt   <= SETUP_LD;
              dq_oe <= 1'b1;
            end else begin
              state     <= R_ACCESS;
              cnt       <= READ_LD;
              sram_cs_n <= 1'b0;
            end
          end
        end
        W_SETUP: begin
          if (cnt == '0) begin
            state     <= W_PULSE;
            cnt       <= PULSE_LD;
            sram_cs_n <= 1'b0;
            sram_we_n <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        W_PULSE: begin
          if (cnt == '0) begin
            state     <= W_HOLD;
            cnt       <= HOLD_LD;
            sram_cs_n <= 1'b1;
            sram_we_n <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        W_HOLD: begin
          if (cnt == '0) begin
            state <= DONE;
            cnt   <= '0;
            dq_oe <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        R_ACCESS: begin
          if (cnt == '0) begin
            state     <= DONE;
            cnt       <= '0;
            rdata     <= sram_dq;
            sram_cs_n <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          dq_oe     <= 1'b0;
          sram_cs_n <= 1'b1;
          sram_we_n <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/baby_store_controller.md
Name: baby_store_controller

Overview:
Sequencing controller between the Baby store logic and a bank of sram_2114 1024x4 chips wired in parallel, giving DATA_WIDTH/4 chips with shared address, CS_n and WE_n.
Converts a single-cycle request into correctly timed 2114 read or write cycles.
Owns the bidirectional data bus: it drives the bus only during writes, while the chips are deselected or writing, so the bus is never in contention.
Sits directly upstream of the SRAM bank; its consumer is the store/CPU sequencing logic.

Parameters:
ADDR_WIDTH, 10, SRAM address width (2114 = 10).
DATA_WIDTH, 32, word width; must be a multiple of 4 (one 2114 per nibble).
SETUP_CYCLES, 1, cycles that address and data are stable with chips deselected before the write strobe.
PULSE_CYCLES, 3, cycles that CS_n and WE_n are both low during a write.
HOLD_CYCLES, 1, cycles that address and data are held after the strobe ends.
READ_CYCLES, 3, cycles that CS_n is low before read data is captured.
All cycle parameters must be >=1. A value of 0 is illegal and is a $error at elaboration.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
req  input  1  start a transaction; sampled only in IDLE.
write  input  1  1 = write, 0 = read; sampled with req.
addr  input  ADDR_WIDTH  word address; sampled with req.
wdata  input  DATA_WIDTH  write data; sampled with req.
rdata  output  DATA_WIDTH  last read word.
busy  output  1  high from the cycle after req is accepted until done.
done  output  1  single-cycle completion pulse.
sram_addr  output  ADDR_WIDTH  address to all chips.
sram_dq  inout  DATA_WIDTH  shared data bus; nibble n goes to chip n.
sram_cs_n  output  1  chip select, active low.
sram_we_n  output  1  write enable, active low.

Behaviour:
- Reset (asynchronous, immediate, including mid-transaction):
  - State = IDLE.
  - sram_cs_n = 1, sram_we_n = 1, sram_dq = Z.
  - sram_addr = 0, rdata = 0, busy = 0, done = 0.
  - A write interrupted by reset leaves the target word undefined; no other word may be disturbed.
- All outputs are registered. The counter is wide enough for the largest cycle parameter and is reloaded on every state entry.
- IDLE:
  - cs_n = 1, we_n = 1, dq = Z.
  - On an edge with req = 1: latch addr, wdata and write; drive sram_addr; busy = 1.
  - Next state is W_SETUP if write = 1, otherwise R_ACCESS.
- W_SETUP (SETUP_CYCLES): cs_n = 1, we_n = 1, dq driven with the latched data.
- W_PULSE (PULSE_CYCLES): cs_n = 0, we_n = 0, dq driven.
- W_HOLD (HOLD_CYCLES): cs_n = 1, we_n = 1, dq still driven, address unchanged.
- R_ACCESS (READ_CYCLES): cs_n = 0, we_n = 1, dq = Z.
  - On the edge that ends the last cycle, rdata <= sram_dq, captured verbatim including any X or Z.
- DONE (1 cycle):
  - cs_n = 1, we_n = 1, dq = Z, done = 1, busy = 0.
  - Next state is IDLE.
- Invariants:
  - dq is never driven while (cs_n = 0 and we_n = 1).
  - sram_addr changes only in IDLE.
  - we_n never falls in the same cycle that the address changes.
- Latency, counted from the req-accept edge to the edge that raises done:
  - write = SETUP_CYCLES + PULSE_CYCLES + HOLD_CYCLES (defaults: 5).
  - read = READ_CYCLES (defaults: 3).
- rdata holds its value until the next read completes; writes do not change it.
- req is ignored while busy or in DONE. If req is held high, the next transaction is accepted on the IDLE edge after DONE, giving a minimum gap of 1 idle cycle.
- Address wrap: none; any address up to 2^ADDR_WIDTH-1 is valid.

Test Plan:
- Setup for all scenarios:
  - Eight sram_2114 instances; clk period 250 ns, so READ_CYCLES x period exceeds the 2114 access delay.
  - Memory is preloaded to 0.
  - Every scenario checks that sram_dq is never driven by the controller while cs_n = 0 and we_n = 1.
- Write 0xDEADBEEF to 0x000, then read 0x000 → rdata = 0xDEADBEEF. done pulses once per transaction, exactly 5 and 3 cycles after each accept edge.
- Write 0x12345678 to 0x3FF and 0xA5A5A5A5 to 0x001, then read 0x3FF → 0x12345678, read 0x001 → 0xA5A5A5A5, read 0x000 → 0xDEADBEEF.
- Hold req high across four back-to-back writes to 0x100..0x103 (values 1..4):
  - Exactly one IDLE cycle separates each done from the next busy.
  - Readback returns 1, 2, 3, 4.
- Pulse req while busy during a write to 0x200 = 0xFFFFFFFF → the extra request is ignored, 0x200 = 0xFFFFFFFF, and the following read of 0x300 returns 0.
- Assert reset_n low during W_PULSE of a write to 0x050:
  - cs_n, we_n go to 1 and dq goes to Z with no clock edge.
  - busy = 0, rdata = 0.
  - A subsequent read of 0x000 still returns 0xDEADBEEF.
- Rebuild with SETUP_CYCLES = 2, PULSE_CYCLES = 4, HOLD_CYCLES = 2, READ_CYCLES = 5 → write latency 8 and read latency 5, checked with a write/read of 0x0F0F0F0F to 0x2AA.
